// File: rtl/seq_shifter.sv
// -----------------------------------------------------------------------------
// seq_shifter
//
// Multi-cycle barrel-shift substitute. It shifts one bit per clock until the
// requested distance is reached. A request is accepted in IDLE or DONE. The
// operand, distance and operation are latched on acceptance, so later changes
// on the inputs do not affect the operation in progress. The result is
// published on dout only when the operation completes. Intermediate shift
// values never appear on dout.
//
// Parameters
//   WIDTH  data width in bits (must equal 2**AW)
//   AW     shift-amount width
//
// Ports
//   clk    single clock, rising edge
//   rst    asynchronous, active-high reset
//   start  request, sampled on the rising edge of clk
//   din    operand, captured on acceptance
//   amt    shift distance 0..WIDTH-1, captured on acceptance
//   op     00 logical left, 01 logical right, 10 arithmetic right,
//          11 rotate left; captured on acceptance
//   busy   high while shift steps are in progress
//   done   one-cycle pulse marking that dout holds a new result
//   dout   result register, stable until the next operation completes
// -----------------------------------------------------------------------------
module seq_shifter #(
   parameter int WIDTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] din,
   input  logic [AW-1:0]    amt,
   input  logic [1:0]       op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] dout
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      OP_LSL = 2'b00,
      OP_LSR = 2'b01,
      OP_ASR = 2'b10,
      OP_ROL = 2'b11
   } op_t;

   state_t           state, state_nxt;
   op_t              op_q, op_nxt;
   logic [WIDTH-1:0] work, work_nxt;
   logic [WIDTH-1:0] dout_nxt;
   logic [WIDTH-1:0] stepped;
   logic [AW-1:0]    cnt, cnt_nxt;
   logic             accept;

   // One 1-bit step of the latched operation applied to the working register.
   always_comb begin
      unique case (op_q)
         OP_LSL:  stepped = {work[WIDTH-2:0], 1'b0};
         OP_LSR:  stepped = {1'b0, work[WIDTH-1:1]};
         OP_ASR:  stepped = {work[WIDTH-1], work[WIDTH-1:1]};
         OP_ROL:  stepped = {work[WIDTH-2:0], work[WIDTH-1]};
         default: stepped = work;
      endcase
   end

   // Next-state logic. dout is loaded only on the transition into DONE. This
   // keeps it steady through SHIFT and also across a back-to-back acceptance
   // from DONE.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      state_nxt = state;
      op_nxt    = op_q;
      work_nxt  = work;
      cnt_nxt   = cnt;
      dout_nxt  = dout;
      accept    = start && (state != SHIFT);

      if (accept) begin
         work_nxt = din;
         cnt_nxt  = amt;
         op_nxt   = op_t'(op);
         if (amt == '0) begin
            state_nxt = DONE;
            dout_nxt  = din;
         end else begin
            state_nxt = SHIFT;
         end
      end else begin
         unique case (state)
            SHIFT: begin
               work_nxt = stepped;
               cnt_nxt  = cnt - 1'b1;
               // The counter reaches zero on this edge, so finish here.
               if (cnt == AW'(1)) begin
                  state_nxt = DONE;
                  dout_nxt  = stepped;
               end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only. This way every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         op_q  <= OP_LSL;
         work  <= '0;
         cnt   <= '0;
         dout  <= '0;
      end else begin
         state <= state_nxt;
         op_q  <= op_nxt;
         work  <= work_nxt;
         cnt   <= cnt_nxt;
         dout  <= dout_nxt;
      end
   end

   // Both flags decode straight from the state register. The asynchronous
   // reset therefore clears them immediately, and that also removes any
   // pending done pulse.
   assign busy = (state == SHIFT);
   assign done = (state == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// -----------------------------------------------------------------------------
// tb_seq_shifter
//
// Directed bench for seq_shifter. A table of {din, amt, op, expected} records
// is applied in a loop. The cycle-by-cycle behaviour of busy, done and dout is
// checked for each record. Hand-written sequences follow for the cases that
// span several operations: start ignored during SHIFT, back-to-back start
// from DONE, and reset during SHIFT.
// -----------------------------------------------------------------------------
module tb_seq_shifter;

   localparam int WIDTH = 8;
   localparam int AW    = 3;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] din;
   logic [AW-1:0]    amt;
   logic [1:0]       op;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] dout;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [WIDTH-1:0] din;
      logic [AW-1:0]    amt;
      logic [1:0]       op;
      logic [WIDTH-1:0] exp;
   } vec_t;

   vec_t vecs[11];

   seq_shifter #(.WIDTH(WIDTH), .AW(AW)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .din   (din),
      .amt   (amt),
      .op    (op),
      .busy  (busy),
      .done  (done),
      .dout  (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Present a request and accept it on the next rising edge. Then walk the
   // busy cycles and stop #1 into the done cycle, with start low. After
   // acceptance the inputs are scrambled, because the latched operands must
   // not follow them.
   task automatic run_op(input logic [WIDTH-1:0] d, input logic [AW-1:0] a,
                         input logic [1:0] o, input logic [WIDTH-1:0] exp,
                         input string name);
      logic [WIDTH-1:0] prev;
      prev  = dout;
      start = 1'b1;
      din   = d;
      amt   = a;
      op    = o;
      @(posedge clk);
      #1;
      start = 1'b0;
      din   = ~d;
      amt   = ~a;
      op    = ~o;
      for (int k = 1; k <= int'(a); k++) begin
         check({name, " busy"}, busy, 1'b1);
         check({name, " early done"}, done, 1'b0);
         check({name, " dout held"}, dout, prev);
         @(posedge clk);
         #1;
      end
      check({name, " done"}, done, 1'b1);
      check({name, " busy at done"}, busy, 1'b0);
      check({name, " dout"}, dout, exp);
   endtask

   initial begin
      int done_seen;

      vecs[0]  = '{8'hB5, 3'd3, 2'b00, 8'hA8};
      vecs[1]  = '{8'hB5, 3'd3, 2'b01, 8'h16};
      vecs[2]  = '{8'hB5, 3'd3, 2'b10, 8'hF6};
      vecs[3]  = '{8'hB5, 3'd3, 2'b11, 8'hAD};
      vecs[4]  = '{8'h3C, 3'd0, 2'b10, 8'h3C};
      vecs[5]  = '{8'h80, 3'd7, 2'b10, 8'hFF};
      vecs[6]  = '{8'h01, 3'd7, 2'b00, 8'h80};
      vecs[7]  = '{8'h80, 3'd7, 2'b01, 8'h01};
      vecs[8]  = '{8'hA5, 3'd4, 2'b11, 8'h5A};
      vecs[9]  = '{8'h7F, 3'd2, 2'b10, 8'h1F};
      vecs[10] = '{8'hC3, 3'd7, 2'b11, 8'hE1};

      rst   = 1'b1;
      start = 1'b0;
      din   = '0;
      amt   = '0;
      op    = '0;

      // Reset state, checked between clock edges while rst is high.
      #12;
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset dout", dout, 8'h00);
      rst = 1'b0;
      #1;

      // Table-driven: the first request lands on the first edge after reset.
      // Each operation is followed by one idle cycle, where done must be low
      // and dout must hold.
      foreach (vecs[i]) begin
         run_op(vecs[i].din, vecs[i].amt, vecs[i].op, vecs[i].exp, $sformatf("vec%0d", i));
         @(posedge clk);
         #1;
         check($sformatf("vec%0d idle done", i), done, 1'b0);
         check($sformatf("vec%0d idle busy", i), busy, 1'b0);
         check($sformatf("vec%0d idle dout", i), dout, vecs[i].exp);
      end

      // start pulsed during SHIFT with different operands: it is ignored.
      start = 1'b1; din = 8'hB5; amt = 3'd3; op = 2'b00;
      @(posedge clk); #1;                      // cycle N+1
      start = 1'b0;
      check("ign busy1", busy, 1'b1);
      @(posedge clk); #1;                      // cycle N+2
      check("ign busy2", busy, 1'b1);
      start = 1'b1; din = 8'hFF; amt = 3'd1; op = 2'b11;
      @(posedge clk); #1;                      // cycle N+3
      start = 1'b0;
      check("ign busy3", busy, 1'b1);
      check("ign no early done", done, 1'b0);
      @(posedge clk); #1;                      // cycle N+4
      check("ign done", done, 1'b1);
      check("ign dout", dout, 8'hA8);
      done_seen = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (done) done_seen++;
      end
      check("ign single done", done_seen, 0);
      check("ign dout after", dout, 8'hA8);

      // Back-to-back: start is held high on the done cycle.
      run_op(8'hB5, 3'd2, 2'b01, 8'h2D, "b2b first");
      run_op(8'h81, 3'd1, 2'b11, 8'h03, "b2b second");
      @(posedge clk); #1;
      check("b2b idle done", done, 1'b0);

      // Reset between edges in the middle of SHIFT.
      start = 1'b1; din = 8'hA5; amt = 3'd7; op = 2'b00;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check("rst pre busy", busy, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("rst busy now", busy, 1'b0);
      check("rst done now", done, 1'b0);
      check("rst dout now", dout, 8'h00);
      @(posedge clk); #3;
      rst = 1'b0;
      done_seen = 0;
      for (int k = 0; k < 9; k++) begin
         @(posedge clk); #1;
         if (done || busy) done_seen++;
      end
      check("rst no done/busy", done_seen, 0);
      check("rst dout stays 0", dout, 8'h00);
      run_op(8'hB5, 3'd3, 2'b11, 8'hAD, "post rst");
      @(posedge clk); #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog, so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
